// File: rtl/rob_pkg.sv
// Shared types and defaults for the multi-port reorder buffer.
// Storage typedefs follow these defaults; rob_multi parameters default to the same values.
package rob_pkg;

    localparam int IDW    = 5;
    localparam int DEPTH  = 2 ** IDW;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;
    localparam int N_CDB  = 3;
    localparam int N_RD   = 2;
    localparam int REG_W  = 5;

    typedef logic [IDW-1:0] ptr_t;
    typedef logic [IDW:0]   cnt_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  regaddr;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
        logic              cond;
    } entry_t;

    // Age of id relative to head: 0 for the head, DEPTH-1 for the slot just behind it.
    function automatic cnt_t rob_dist(input ptr_t head, input ptr_t id);
        ptr_t d;
        d = id - head;
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/rob_read_port.sv
// One operand read port: a same-cycle CDB result takes precedence over stored data.
module rob_read_port #(
    parameter int IDW    = 5,
    parameter int DATA_W = 32,
    parameter int N_CDB  = 3
) (
    input  logic                    rd_en_i,
    input  logic [IDW-1:0]          rd_id_i,
    input  logic [N_CDB-1:0]        cdb_en_i,
    input  logic [N_CDB*IDW-1:0]    cdb_id_i,
    input  logic [N_CDB*DATA_W-1:0] cdb_data_i,
    input  logic                    ent_valid_i,
    input  logic                    ent_done_i,
    input  logic [DATA_W-1:0]       ent_data_i,
    output logic                    rd_rdy_o,
    output logic [DATA_W-1:0]       rd_data_o
);

    always_comb begin
        rd_rdy_o  = 1'b0;
        rd_data_o = '0;
        if (rd_en_i && ent_valid_i) begin
            if (ent_done_i) begin
                rd_rdy_o  = 1'b1;
                rd_data_o = ent_data_i;
            end
            // Walk ports high to low so the lowest matching port ends up winning.
            for (int k = N_CDB - 1; k >= 0; k--) begin
                if (cdb_en_i[k] && (cdb_id_i[k*IDW +: IDW] == rd_id_i)) begin
                    rd_rdy_o  = 1'b1;
                    rd_data_o = cdb_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocate/retire, N_CDB result ports, N_RD bypassing read ports,
// occupancy count and younger-than partial flush for branch recovery.
module rob_multi #(
    parameter int IDW    = rob_pkg::IDW,
    parameter int DATA_W = rob_pkg::DATA_W,
    parameter int N_CDB  = rob_pkg::N_CDB,
    parameter int N_RD   = rob_pkg::N_RD,
    parameter int TAG_W  = rob_pkg::TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_c,
    input  logic                    rdy,
    input  logic                    add_en_i,
    input  logic [4:0]              add_regaddr_i,
    input  logic [TAG_W-1:0]        add_branch_tag_i,
    output logic                    add_ready_o,
    output logic [IDW-1:0]          add_id_o,
    output logic [IDW:0]            count_o,
    output logic                    full_o,
    output logic                    empty_o,
    input  logic [N_CDB-1:0]        cdb_en_i,
    input  logic [N_CDB*IDW-1:0]    cdb_id_i,
    input  logic [N_CDB*DATA_W-1:0] cdb_data_i,
    input  logic [N_CDB*DATA_W-1:0] cdb_pc_i,
    input  logic [N_CDB-1:0]        cdb_cond_i,
    input  logic                    flush_en_i,
    input  logic [IDW-1:0]          flush_id_i,
    input  logic [N_RD-1:0]         rd_en_i,
    input  logic [N_RD*IDW-1:0]     rd_id_i,
    output logic [N_RD-1:0]         rd_rdy_o,
    output logic [N_RD*DATA_W-1:0]  rd_data_o,
    output logic                    commit_valid_o,
    input  logic                    commit_ready_i,
    output logic [IDW-1:0]          commit_id_o,
    output logic [4:0]              commit_regaddr_o,
    output logic [DATA_W-1:0]       commit_data_o,
    output logic [DATA_W-1:0]       commit_pc_o,
    output logic [TAG_W-1:0]        commit_branch_tag_o,
    output logic                    commit_cond_o
);

    import rob_pkg::*;

    localparam int DEPTH = 2 ** IDW;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic             full, empty, flush_hit, push, pop;
    logic [DEPTH-1:0] squash;
    logic             cdb_collide;

    always_comb begin
        full           = (count_q == cnt_t'(DEPTH));
        empty          = (count_q == '0);
        flush_hit      = rdy && flush_en_i && ent_q[flush_id_i].valid;
        add_ready_o    = rdy && !full && !flush_hit;
        push           = add_en_i && add_ready_o;
        commit_valid_o = rdy && !empty && ent_q[head_q].done;
        pop            = commit_valid_o && commit_ready_i;
        // Valid entries are exactly [head, head+count), so age from head identifies the younger ones.
        squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = flush_hit && ent_q[i].valid &&
                        (rob_dist(head_q, ptr_t'(i)) > rob_dist(head_q, flush_id_i));
        end
    end

    always_comb begin : next_state
        ptr_t cid;
        cid     = '0;
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy) begin
            for (int k = N_CDB - 1; k >= 0; k--) begin
                cid = cdb_id_i[k*IDW +: IDW];
                if (cdb_en_i[k] && ent_q[cid].valid && !squash[cid]) begin
                    ent_d[cid].done = 1'b1;
                    ent_d[cid].data = cdb_data_i[k*DATA_W +: DATA_W];
                    ent_d[cid].pc   = cdb_pc_i[k*DATA_W +: DATA_W];
                    ent_d[cid].cond = cdb_cond_i[k];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (squash[i]) begin
                    ent_d[i].valid = 1'b0;
                    ent_d[i].done  = 1'b0;
                end
            end
            if (pop) begin
                ent_d[head_q].valid = 1'b0;
                ent_d[head_q].done  = 1'b0;
                head_d = head_q + ptr_t'(1);
            end
            if (push) begin
                ent_d[tail_q].valid   = 1'b1;
                ent_d[tail_q].done    = 1'b0;
                ent_d[tail_q].regaddr = add_regaddr_i;
                ent_d[tail_q].tag     = add_branch_tag_i;
                tail_d = tail_q + ptr_t'(1);
            end
            if (flush_hit) begin
                tail_d  = flush_id_i + ptr_t'(1);
                count_d = rob_dist(head_q, flush_id_i) + cnt_t'(1) - cnt_t'(pop);
            end else begin
                count_d = count_q + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rst_c) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ent_q   <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

    assign add_id_o            = tail_q;
    assign count_o             = count_q;
    assign full_o              = full;
    assign empty_o             = empty;
    assign commit_id_o         = head_q;
    assign commit_regaddr_o    = ent_q[head_q].regaddr;
    assign commit_data_o       = ent_q[head_q].data;
    assign commit_pc_o         = ent_q[head_q].pc;
    assign commit_branch_tag_o = ent_q[head_q].tag;
    assign commit_cond_o       = ent_q[head_q].cond;

    for (genvar j = 0; j < N_RD; j++) begin : g_rd
        ptr_t rid;
        assign rid = rd_id_i[j*IDW +: IDW];
        rob_read_port #(
            .IDW    (IDW),
            .DATA_W (DATA_W),
            .N_CDB  (N_CDB)
        ) u_rd (
            .rd_en_i     (rd_en_i[j]),
            .rd_id_i     (rid),
            .cdb_en_i    (cdb_en_i),
            .cdb_id_i    (cdb_id_i),
            .cdb_data_i  (cdb_data_i),
            .ent_valid_i (ent_q[rid].valid),
            .ent_done_i  (ent_q[rid].done),
            .ent_data_i  (ent_q[rid].data),
            .rd_rdy_o    (rd_rdy_o[j]),
            .rd_data_o   (rd_data_o[j*DATA_W +: DATA_W])
        );
    end

    // Two CDB ports targeting one id is an upstream protocol error; hardware keeps the lowest port.
    always_comb begin
        cdb_collide = 1'b0;
        for (int a = 0; a < N_CDB; a++) begin
            for (int b = a + 1; b < N_CDB; b++) begin
                if (cdb_en_i[a] && cdb_en_i[b] &&
                    (cdb_id_i[a*IDW +: IDW] == cdb_id_i[b*IDW +: IDW])) begin
                    cdb_collide = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !rst_c && rdy) begin
            assert (!cdb_collide)
                else $warning("rob_multi: two CDB ports target one id, lowest port kept");
        end
    end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised reorder buffer: the next-generation ROB for the out-of-order RISC-V core.
- Allocates entries in program order from the decoder and accepts results from N_CDB common data buses.
- Supplies operand forwarding to N_RD decoder read ports and retires in order through a valid/ready commit handshake.
- Adds full-depth usage, an explicit occupancy count, and partial (younger-than) flush for branch recovery.

Parameters:
- IDW, 5: entry-id width; DEPTH = 2**IDW entries, all usable.
- DATA_W, 32: result and PC width.
- N_CDB, 3: number of CDB write ports.
- N_RD, 2: number of operand read ports.
- TAG_W, 2: branch-tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rst_c  in  1  synchronous full flush; same effect as rst.
- rdy  in  1  global enable; when low, all state holds.
- add_en_i  in  1  allocate request.
- add_regaddr_i  in  5  destination register.
- add_branch_tag_i  in  TAG_W  branch tag.
- add_ready_o  out  1  allocation possible this cycle.
- add_id_o  out  IDW  id assigned to the current request (equals tail).
- count_o  out  IDW+1  occupancy.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- cdb_en_i  in  N_CDB  per-port write strobe.
- cdb_id_i  in  N_CDB*IDW  target ids, port k at bits [k*IDW +: IDW].
- cdb_data_i  in  N_CDB*DATA_W  results.
- cdb_pc_i  in  N_CDB*DATA_W  resolved PCs; tie to 0 on ports without a PC.
- cdb_cond_i  in  N_CDB  branch outcome.
- flush_en_i  in  1  squash all entries younger than flush_id_i.
- flush_id_i  in  IDW  last surviving entry.
- rd_en_i  in  N_RD  read enables.
- rd_id_i  in  N_RD*IDW  read ids.
- rd_rdy_o  out  N_RD  operand available.
- rd_data_o  out  N_RD*DATA_W  operand value.
- commit_valid_o  out  1  head entry ready to retire.
- commit_ready_i  in  1  retire accepted.
- commit_id_o  out  IDW  head id.
- commit_regaddr_o  out  5  head destination register.
- commit_data_o  out  DATA_W  head result.
- commit_pc_o  out  DATA_W  head PC.
- commit_branch_tag_o  out  TAG_W  head branch tag.
- commit_cond_o  out  1  head branch outcome.

Behaviour:
- State: head, tail (IDW bits, modulo DEPTH); count (IDW+1 bits); per-entry valid, done, regaddr, tag, data, pc, cond.
- Reset / rst_c:
  - head = tail = count = 0; all valid and done bits cleared.
  - commit_valid_o = 0, add_ready_o = 1, empty_o = 1, full_o = 0, rd_rdy_o = 0.
  - rst and rst_c take priority over rdy and every other input.
- rdy low: no push, pop, CDB write or flush; add_ready_o = 0; commit_valid_o = 0; read ports stay combinational.
- Push:
  - Fires when add_en_i && add_ready_o; add_ready_o = rdy && !full.
  - There is no pass-through: a full ROB refuses the push even if a pop occurs in the same cycle.
  - A push writes entry[tail] with valid = 1, done = 0; tail advances by 1, wrapping DEPTH-1 -> 0.
  - add_id_o is combinational (= tail). The id is usable in the same cycle.
- CDB write:
  - For each enabled port k with valid[id] set: done = 1 and data/pc/cond are written.
  - Writes to invalid entries are ignored.
  - If two ports target the same id, the lowest k wins; this is a protocol error and carries a sim assertion.
- Pop:
  - commit_valid_o = rdy && !empty && done[head]; commit_* fields are combinational from entry[head].
  - A pop fires when commit_valid_o && commit_ready_i; it clears valid[head] and head advances.
  - Zero latency: a result written by CDB in cycle N is eligible for commit in cycle N+1.
- Count: count_next = count + push - pop - squashed.
- Partial flush (flush_en_i, applies only when valid[flush_id_i]; otherwise ignored):
  - Entries (flush_id_i, tail) are invalidated and tail = flush_id_i + 1.
  - count = ((flush_id_i - head) mod DEPTH) + 1 - pop.
  - Flush overrides a same-cycle push: no push, and add_ready_o is forced to 0.
  - Same-cycle CDB writes to squashed ids are dropped.
  - A same-cycle pop still retires the head. If flush_id_i == head and a pop fires, the ROB becomes empty.
- Read port j:
  - Priority: !rd_en -> rdy 0, data 0; matching CDB port (lowest k first) -> rdy 1, CDB data; done[id] -> rdy 1, stored data; else rdy 0, data 0.
  - A match requires valid[id]; the read path is fully combinational.
- Wrap-around: all pointer arithmetic is modulo DEPTH. Full and empty are distinguished only by count.

Decomposition:
- Package rob_pkg: IDW, DEPTH, DATA_W, TAG_W defaults; entry struct typedef; ptr_t and cnt_t typedefs; helper function for the modulo distance (head to id).
- Sub-module rob_read_port: one combinational CDB-bypass mux, instantiated N_RD times via generate.

Test Plan:
- Reset, then 32 pushes with no pops -> ids 0..31, full_o = 1 after the 32nd, add_ready_o = 0; a 33rd add_en_i is ignored and count stays 32.
- Push ids 0,1,2; CDB writes id1 then id0 (data 0xA, 0xB) -> commit_valid_o is held until id0 is done; commits come out in order 0(0xB), 1(0xA); id2 stays pending.
- Same-cycle CDB0 and CDB2 to id 3 (0x11 / 0x22) while read port 0 asks for id 3 -> rd_data = 0x11; stored data = 0x11.
- head = 30, tail = 4 (wrapped, count 6); flush_en_i with id 31 plus a pop -> tail = 0, count = 1, entries 0..3 invalid; a later CDB to id 2 is ignored.
- commit_ready_i held low 5 cycles with the head done -> commit_valid_o stays 1 and head is unchanged; rdy low 3 cycles -> no state change.
- rst_c pulsed mid-traffic (count 17) -> next cycle count 0, empty_o 1, commit_valid_o 0, add_id_o 0.
